// File: rtl/cnn_mem_arbiter.sv
// rtl/cnn_mem_arbiter.sv - round-robin host/engine arbiter for a shared single-port CNN memory
module cnn_mem_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writedata,
    output logic              waitrequest,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid,
    input  logic              eng_req,
    input  logic              eng_we,
    input  logic              eng_lock,
    input  logic [ADDR_W-1:0] eng_addr,
    input  logic [DATA_W-1:0] eng_wdata,
    output logic              eng_gnt,
    output logic [DATA_W-1:0] eng_rdata,
    output logic              eng_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_HOST = 2'd1,
        OWN_ENG  = 2'd2
    } owner_t;

    logic       host_req;
    logic       host_gnt;
    logic       last_eng;
    logic [7:0] burst_cnt;
    owner_t     own_q;
    owner_t     own_d;

    assign host_req    = chipselect & (read | write);
    assign waitrequest = host_req & ~host_gnt;

    always_comb begin
        host_gnt = 1'b0;
        eng_gnt  = 1'b0;
        if (host_req && eng_req) begin
            // a locked engine keeps priority until its burst allowance runs out
            if (eng_lock) begin
                if (burst_cnt < BURST_LIM) eng_gnt = 1'b1;
                else                       host_gnt = 1'b1;
            end else if (last_eng) begin
                host_gnt = 1'b1;
            end else begin
                eng_gnt = 1'b1;
            end
        end else begin
            host_gnt = host_req;
            eng_gnt  = eng_req;
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        own_d     = OWN_NONE;
        if (host_gnt) begin
            mem_addr  = address;
            mem_wdata = writedata;
            mem_we    = write;
            mem_re    = read & ~write;
            if (read && !write) own_d = OWN_HOST;
        end else if (eng_gnt) begin
            mem_addr  = eng_addr;
            mem_wdata = eng_wdata;
            mem_we    = eng_we;
            mem_re    = ~eng_we;
            if (!eng_we) own_d = OWN_ENG;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_eng      <= 1'b1;
            burst_cnt     <= '0;
            own_q         <= OWN_NONE;
            readdata      <= '0;
            readdatavalid <= 1'b0;
            eng_rdata     <= '0;
            eng_rvalid    <= 1'b0;
        end else begin
            if (host_gnt)     last_eng <= 1'b0;
            else if (eng_gnt) last_eng <= 1'b1;

            if (host_gnt || !host_req)
                burst_cnt <= '0;
            else if (eng_gnt && burst_cnt < BURST_LIM)
                burst_cnt <= burst_cnt + 8'd1;

            // own_q tags the read issued last cycle; the valid flops form the second stage
            own_q         <= own_d;
            readdatavalid <= (own_q == OWN_HOST);
            eng_rvalid    <= (own_q == OWN_ENG);
            if (own_q == OWN_HOST) readdata  <= mem_rdata;
            if (own_q == OWN_ENG)  eng_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_cnn_mem_arbiter.sv
// tb/tb_cnn_mem_arbiter.sv - directed self-checking bench for cnn_mem_arbiter
module tb_cnn_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       chipselect, read, write;
    logic [7:0] address, writedata;
    logic       waitrequest;
    logic [7:0] readdata;
    logic       readdatavalid;
    logic       eng_req, eng_we, eng_lock;
    logic [7:0] eng_addr, eng_wdata;
    logic       eng_gnt;
    logic [7:0] eng_rdata;
    logic       eng_rvalid;
    logic [7:0] mem_addr;
    logic       mem_we, mem_re;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    logic [7:0] mem [0:255];

    int n_pass  = 0;
    int n_total = 0;

    cnn_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .chipselect(chipselect), .read(read), .write(write),
        .address(address), .writedata(writedata),
        .waitrequest(waitrequest), .readdata(readdata), .readdatavalid(readdatavalid),
        .eng_req(eng_req), .eng_we(eng_we), .eng_lock(eng_lock),
        .eng_addr(eng_addr), .eng_wdata(eng_wdata),
        .eng_gnt(eng_gnt), .eng_rdata(eng_rdata), .eng_rvalid(eng_rvalid),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic host(input logic cs, input logic rd, input logic wr,
                        input logic [7:0] a, input logic [7:0] d);
        chipselect = cs; read = rd; write = wr; address = a; writedata = d;
    endtask

    task automatic eng(input logic rq, input logic we, input logic lk,
                       input logic [7:0] a, input logic [7:0] d);
        eng_req = rq; eng_we = we; eng_lock = lk; eng_addr = a; eng_wdata = d;
    endtask

    task automatic idle();
        host(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        eng(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        mem_rdata = 8'h00;
        reset = 1'b0;
        idle();
        cyc(); cyc();
        #1;
        chk("rst_rdv", readdatavalid, 1'b0);
        chk("rst_ervalid", eng_rvalid, 1'b0);
        chk("rst_rdata", readdata, 8'h00);
        chk("rst_erdata", eng_rdata, 8'h00);
        chk("rst_wait", waitrequest, 1'b0);
        cyc();
        reset = 1'b1;

        // host write then read of 0x05
        cyc(); host(1'b1, 1'b0, 1'b1, 8'h05, 8'hA7); #1;
        chk("t1_wr_wait", waitrequest, 1'b0);
        chk("t1_wr_we", mem_we, 1'b1);
        chk("t1_wr_addr", mem_addr, 8'h05);
        chk("t1_wr_data", mem_wdata, 8'hA7);
        cyc(); host(1'b1, 1'b1, 1'b0, 8'h05, 8'h00); #1;
        chk("t1_rd_wait", waitrequest, 1'b0);
        chk("t1_rd_re", mem_re, 1'b1);
        cyc(); idle(); #1;
        chk("t1_rdv_n1", readdatavalid, 1'b0);
        cyc(); #1;
        chk("t1_rdv_n2", readdatavalid, 1'b1);
        chk("t1_rdata", readdata, 8'hA7);
        cyc(); #1;
        chk("t1_rdv_n3", readdatavalid, 1'b0);
        chk("t1_rdata_hold", readdata, 8'hA7);

        // engine writes 0x06 = 0x3C, then reset so the host wins the first contention
        cyc(); eng(1'b1, 1'b1, 1'b0, 8'h06, 8'h3C); #1;
        chk("eng_wr_gnt", eng_gnt, 1'b1);
        chk("eng_wr_we", mem_we, 1'b1);
        cyc(); idle(); reset = 1'b0;
        cyc(); cyc(); reset = 1'b1;

        // contention without lock: H,E,H,E
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (i < 4) begin
                host(1'b1, 1'b1, 1'b0, 8'h05, 8'h00);
                eng(1'b1, 1'b0, 1'b0, 8'h06, 8'h00);
            end else begin
                idle();
            end
            #1;
            if (i < 4) begin
                chk($sformatf("t2_hgnt%0d", i), waitrequest, (i % 2 == 1));
                chk($sformatf("t2_egnt%0d", i), eng_gnt, (i % 2 == 1));
            end
            chk($sformatf("t2_rdv%0d", i), readdatavalid, (i == 2 || i == 4));
            chk($sformatf("t2_erv%0d", i), eng_rvalid, (i == 3 || i == 5));
            if (i >= 2) begin
                chk($sformatf("t2_rdata%0d", i), readdata, 8'hA7);
                if (i >= 3) chk($sformatf("t2_erdata%0d", i), eng_rdata, 8'h3C);
            end
        end

        // locked engine burst, MAX_BURST = 4
        for (int i = 0; i < 7; i++) begin
            cyc();
            if (i < 5) begin
                host(1'b1, 1'b1, 1'b0, 8'h05, 8'h00);
                eng(1'b1, 1'b0, 1'b1, 8'h06, 8'h00);
            end else begin
                idle();
            end
            #1;
            if (i < 5) begin
                chk($sformatf("t3_egnt%0d", i), eng_gnt, (i < 4));
                chk($sformatf("t3_wait%0d", i), waitrequest, (i < 4));
            end
            if (i == 5) chk("t3_burst_clr", dut.burst_cnt, 8'd0);
            chk($sformatf("t3_erv%0d", i), eng_rvalid, (i >= 2 && i <= 5));
            chk($sformatf("t3_rdv%0d", i), readdatavalid, (i == 6));
        end
        chk("t3_rdata", readdata, 8'hA7);
        chk("t3_erdata", eng_rdata, 8'h3C);

        // engine read then host read on consecutive cycles; write distinct data first
        cyc(); host(1'b1, 1'b0, 1'b1, 8'h20, 8'h11); #1;
        cyc(); host(1'b0, 1'b0, 1'b0, 8'h00, 8'h00); eng(1'b1, 1'b0, 1'b0, 8'h06, 8'h00); #1;
        chk("t4_egnt", eng_gnt, 1'b1);
        cyc(); eng(1'b0, 1'b0, 1'b0, 8'h00, 8'h00); host(1'b1, 1'b1, 1'b0, 8'h20, 8'h00); #1;
        chk("t4_hgnt", waitrequest, 1'b0);
        cyc(); idle(); #1;
        chk("t4_erv_n2", eng_rvalid, 1'b1);
        chk("t4_rdv_n2", readdatavalid, 1'b0);
        chk("t4_erdata", eng_rdata, 8'h3C);
        cyc(); #1;
        chk("t4_erv_n3", eng_rvalid, 1'b0);
        chk("t4_rdv_n3", readdatavalid, 1'b1);
        chk("t4_rdata", readdata, 8'h11);

        // reset the cycle after a host read grant discards the return
        cyc(); host(1'b1, 1'b1, 1'b0, 8'h05, 8'h00); #1;
        chk("t5_gnt", waitrequest, 1'b0);
        cyc(); idle(); reset = 1'b0; #1;
        chk("t5_rst_rdv", readdatavalid, 1'b0);
        chk("t5_rst_erv", eng_rvalid, 1'b0);
        cyc(); #1;
        chk("t5_rst_rdv2", readdatavalid, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            chk($sformatf("t5_post_rdv%0d", i), readdatavalid, 1'b0);
            chk($sformatf("t5_post_erv%0d", i), eng_rvalid, 1'b0);
        end

        // read and write both high is a write
        cyc(); host(1'b1, 1'b1, 1'b1, 8'h10, 8'h55); #1;
        chk("t6_we", mem_we, 1'b1);
        chk("t6_re", mem_re, 1'b0);
        chk("t6_wait", waitrequest, 1'b0);
        cyc(); host(1'b1, 1'b1, 1'b0, 8'h10, 8'h00); #1;
        chk("t6_rd_re", mem_re, 1'b1);
        cyc(); idle(); #1;
        chk("t6_rdv_n1", readdatavalid, 1'b0);
        cyc(); #1;
        chk("t6_rdv_n2", readdatavalid, 1'b1);
        chk("t6_rdata", readdata, 8'h55);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
